// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified I/D memory arbiter.
//   arb_state_e   : arbiter FSM states
//   grant_e       : which requester owns the RAM port
//   rd_ctx_t      : context captured when a read is accepted
//   MEM_BASE_ADDR : default byte address of RAM word 0
//   MEM_IDX_W     : default RAM word-index width
//   strb2mask     : byte strobes -> per-bit write mask
package mem_arb_pkg;

  localparam logic [63:0] MEM_BASE_ADDR = 64'h8000_0000;
  localparam int unsigned MEM_IDX_W     = 28;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RSP_I = 2'd1,
    RSP_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_IBUS = 1'b0,
    GNT_DBUS = 1'b1
  } grant_e;

  // Everything needed to form the response one cycle after the grant.
  typedef struct packed {
    logic err;       // address was outside the RAM window
    logic word_sel;  // which 32-bit half of the RAM word a fetch wants
  } rd_ctx_t;

  // Replicate each strobe bit across its byte lane.
  function automatic logic [63:0] strb2mask(input logic [7:0] strb);
    logic [63:0] mask;
    mask = '0;
    for (int i = 0; i < 8; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/mem_addr_xlate.sv
// Byte address -> RAM word index translation with window check.
//   addr     in   64     byte address from a requester
//   idx      out  IDX_W  RAM word index ((addr - BASE_ADDR) / 8)
//   in_range out  1      address lies inside [BASE_ADDR, BASE_ADDR + 2^(IDX_W+3))
//   word_sel out  1      upper/lower 32-bit half of the 64-bit RAM word
import mem_arb_pkg::*;

module mem_addr_xlate #(
  parameter logic [63:0] BASE_ADDR = MEM_BASE_ADDR,
  parameter int unsigned IDX_W     = MEM_IDX_W
) (
  input  logic [63:0]      addr,
  output logic [IDX_W-1:0] idx,
  output logic             in_range,
  output logic             word_sel
);

  logic [63:0] offset;

  // Unsigned subtraction: addresses below BASE_ADDR wrap high and fail the check.
  assign offset   = addr - BASE_ADDR;
  assign in_range = (offset >> (IDX_W + 3)) == 64'd0;
  assign idx      = offset[IDX_W+2:3];
  assign word_sel = offset[2];

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one synchronous single-port RAM between the instruction fetch bus
// (ibus) and the load/store bus (dbus).
//   clock, reset (sync, active-high)
//   ibus_cmd_* / ibus_rsp_* : 32-bit fetch requests and responses
//   dbus_cmd_* / dbus_rsp_* : 64-bit load/store requests and load responses
//   ram_*                   : RAMHelper-style port, read data valid the cycle after ram_en
// Reads occupy the port for two cycles (grant, response); stores complete in
// the grant cycle so back-to-back stores run at one per cycle.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration on ties;
// otherwise dbus has fixed priority over ibus.
import mem_arb_pkg::*;

module unified_mem_arbiter #(
  parameter logic [63:0] BASE_ADDR = MEM_BASE_ADDR,
  parameter int unsigned IDX_W     = MEM_IDX_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ibus_cmd_valid,
  output logic             ibus_cmd_ready,
  input  logic [63:0]      ibus_cmd_addr,
  output logic             ibus_rsp_valid,
  output logic [31:0]      ibus_rsp_data,
  output logic             ibus_rsp_err,
  input  logic             dbus_cmd_valid,
  output logic             dbus_cmd_ready,
  input  logic [63:0]      dbus_cmd_addr,
  input  logic             dbus_cmd_wen,
  input  logic [63:0]      dbus_cmd_wdata,
  input  logic [7:0]       dbus_cmd_wstrb,
  output logic             dbus_rsp_valid,
  output logic [63:0]      dbus_rsp_data,
  output logic             dbus_rsp_err,
  output logic             ram_en,
  output logic [IDX_W-1:0] ram_idx,
  output logic             ram_wen,
  output logic [63:0]      ram_wdata,
  output logic [63:0]      ram_wmask,
  input  logic [63:0]      ram_rdata
);

  arb_state_e       state_q, state_d;
  rd_ctx_t          rd_ctx_q, rd_ctx_d;
  grant_e           tie_winner;
  logic             gnt_i, gnt_d;
  logic [IDX_W-1:0] i_idx, d_idx;
  logic             i_in_range, d_in_range;
  logic             i_word_sel, d_word_sel;

  // Per-requester address translation.
  mem_addr_xlate #(.BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_ibus_xlate (
    .addr     (ibus_cmd_addr),
    .idx      (i_idx),
    .in_range (i_in_range),
    .word_sel (i_word_sel)
  );

  mem_addr_xlate #(.BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)) u_dbus_xlate (
    .addr     (dbus_cmd_addr),
    .idx      (d_idx),
    .in_range (d_in_range),
    .word_sel (d_word_sel)
  );

  // Who wins when both requesters are valid in IDLE.
`ifdef MEM_ARB_RR_EN
  grant_e last_grant_q, last_grant_d;

  assign tie_winner = (last_grant_q == GNT_IBUS) ? GNT_DBUS : GNT_IBUS;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant_q <= GNT_IBUS;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign tie_winner = GNT_DBUS;
`endif

  // State and read-context registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rd_ctx_q <= '0;
    end else begin
      state_q  <= state_d;
      rd_ctx_q <= rd_ctx_d;
    end
  end

  // Next state, grant and RAM/response outputs; everything held low during reset.
  always_comb begin
    state_d        = state_q;
    rd_ctx_d       = rd_ctx_q;
    gnt_i          = 1'b0;
    gnt_d          = 1'b0;
    ibus_cmd_ready = 1'b0;
    dbus_cmd_ready = 1'b0;
    ibus_rsp_valid = 1'b0;
    ibus_rsp_data  = '0;
    ibus_rsp_err   = 1'b0;
    dbus_rsp_valid = 1'b0;
    dbus_rsp_data  = '0;
    dbus_rsp_err   = 1'b0;
    ram_en         = 1'b0;
    ram_idx        = '0;
    ram_wen        = 1'b0;
    ram_wdata      = '0;
    ram_wmask      = '0;
`ifdef MEM_ARB_RR_EN
    last_grant_d   = last_grant_q;
`endif

    if (!reset) begin
      unique case (state_q)
        IDLE: begin
          gnt_d          = dbus_cmd_valid && (!ibus_cmd_valid || (tie_winner == GNT_DBUS));
          gnt_i          = ibus_cmd_valid && !gnt_d;
          ibus_cmd_ready = gnt_i;
          dbus_cmd_ready = gnt_d;

          if (gnt_i) begin
            // Out-of-range fetches still take the response slot to report the error.
            ram_en            = i_in_range;
            ram_idx           = i_in_range ? i_idx : '0;
            rd_ctx_d.err      = !i_in_range;
            rd_ctx_d.word_sel = i_word_sel;
            state_d           = RSP_I;
`ifdef MEM_ARB_RR_EN
            last_grant_d      = GNT_IBUS;
`endif
          end else if (gnt_d) begin
            ram_en  = d_in_range;
            ram_idx = d_in_range ? d_idx : '0;
            if (dbus_cmd_wen) begin
              // Stores finish here; out-of-range stores are dropped.
              ram_wen   = d_in_range;
              ram_wdata = d_in_range ? dbus_cmd_wdata : '0;
              ram_wmask = d_in_range ? strb2mask(dbus_cmd_wstrb) : '0;
            end else begin
              rd_ctx_d.err      = !d_in_range;
              rd_ctx_d.word_sel = d_word_sel;
              state_d           = RSP_D;
            end
`ifdef MEM_ARB_RR_EN
            last_grant_d = GNT_DBUS;
`endif
          end
        end

        RSP_I: begin
          ibus_rsp_valid = 1'b1;
          ibus_rsp_err   = rd_ctx_q.err;
          if (!rd_ctx_q.err) begin
            ibus_rsp_data = rd_ctx_q.word_sel ? ram_rdata[63:32] : ram_rdata[31:0];
          end
          state_d = IDLE;
        end

        RSP_D: begin
          dbus_rsp_valid = 1'b1;
          dbus_rsp_err   = rd_ctx_q.err;
          if (!rd_ctx_q.err) begin
            dbus_rsp_data = ram_rdata;
          end
          state_d = IDLE;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios followed by
// randomized traffic, all checked against a request-level reference model
// (pending-read record plus a byte-address keyed memory image).
// Define MEM_ARB_RR_EN to check the round-robin build.
module tb_unified_mem_arbiter;

  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] WIN  = 64'h8000_0000;  // 2^(28+3) bytes
`ifdef MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ibus_cmd_valid = 1'b0;
  logic [63:0] ibus_cmd_addr = '0;
  logic        dbus_cmd_valid = 1'b0;
  logic [63:0] dbus_cmd_addr = '0;
  logic        dbus_cmd_wen = 1'b0;
  logic [63:0] dbus_cmd_wdata = '0;
  logic [7:0]  dbus_cmd_wstrb = '0;
  logic [63:0] ram_rdata;
  logic        ibus_cmd_ready, ibus_rsp_valid, ibus_rsp_err;
  logic [31:0] ibus_rsp_data;
  logic        dbus_cmd_ready, dbus_rsp_valid, dbus_rsp_err;
  logic [63:0] dbus_rsp_data;
  logic        ram_en, ram_wen;
  logic [27:0] ram_idx;
  logic [63:0] ram_wdata, ram_wmask;

  always #5 clock = ~clock;

  unified_mem_arbiter dut (
    .clock          (clock),
    .reset          (reset),
    .ibus_cmd_valid (ibus_cmd_valid),
    .ibus_cmd_ready (ibus_cmd_ready),
    .ibus_cmd_addr  (ibus_cmd_addr),
    .ibus_rsp_valid (ibus_rsp_valid),
    .ibus_rsp_data  (ibus_rsp_data),
    .ibus_rsp_err   (ibus_rsp_err),
    .dbus_cmd_valid (dbus_cmd_valid),
    .dbus_cmd_ready (dbus_cmd_ready),
    .dbus_cmd_addr  (dbus_cmd_addr),
    .dbus_cmd_wen   (dbus_cmd_wen),
    .dbus_cmd_wdata (dbus_cmd_wdata),
    .dbus_cmd_wstrb (dbus_cmd_wstrb),
    .dbus_rsp_valid (dbus_rsp_valid),
    .dbus_rsp_data  (dbus_rsp_data),
    .dbus_rsp_err   (dbus_rsp_err),
    .ram_en         (ram_en),
    .ram_idx        (ram_idx),
    .ram_wen        (ram_wen),
    .ram_wdata      (ram_wdata),
    .ram_wmask      (ram_wmask),
    .ram_rdata      (ram_rdata)
  );

  // Initial RAM contents, restored on every reset (32 words, index modulo 32).
  function automatic logic [63:0] seed_word(input int i);
    return {32'hC0DE_0000 | 32'(i), 32'hF00D_0000 | 32'(i)};
  endfunction

  // RAMHelper-style synchronous RAM driven by the DUT's RAM port.
  logic [63:0] ram_mem [32];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= seed_word(i);
    end else if (ram_en) begin
      if (ram_wen)
        ram_mem[ram_idx[4:0]] <= (ram_mem[ram_idx[4:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
      else
        ram_rdata <= ram_mem[ram_idx[4:0]];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic expect_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: memory image, one outstanding read, last granted requester.
  logic [63:0] ref_mem [32];
  bit          pend_v, pend_i, pend_err, last_d;
  logic [63:0] pend_data;

  // Observations from the most recent step, for directed checks.
  bit          snap_ri, snap_rd, snap_en, snap_wen, snap_iv, snap_dv, snap_ierr, snap_derr;
  logic [27:0] snap_idx;
  logic [63:0] snap_wmask, snap_ddata;
  logic [31:0] snap_idata;

  // One clock cycle: drive inputs, check settled outputs against the model, advance.
  task automatic step(input bit rst, input bit iv, input logic [63:0] ia,
                      input bit dv, input logic [63:0] da, input bit dw,
                      input logic [63:0] dwd, input logic [7:0] dst,
                      output bit acc_i, output bit acc_d);
    bit          gi, gd, e_iv, e_dv, e_err, inr, store;
    logic [63:0] e_data, a, off, w, mask, val;
    reset = rst; ibus_cmd_valid = iv; ibus_cmd_addr = ia;
    dbus_cmd_valid = dv; dbus_cmd_addr = da; dbus_cmd_wen = dw;
    dbus_cmd_wdata = dwd; dbus_cmd_wstrb = dst;
    @(negedge clock);
    snap_ri = ibus_cmd_ready; snap_rd = dbus_cmd_ready; snap_en = ram_en; snap_wen = ram_wen;
    snap_idx = ram_idx; snap_wmask = ram_wmask; snap_iv = ibus_rsp_valid; snap_dv = dbus_rsp_valid;
    snap_idata = ibus_rsp_data; snap_ddata = dbus_rsp_data; snap_ierr = ibus_rsp_err; snap_derr = dbus_rsp_err;

    gi = 1'b0; gd = 1'b0; e_iv = 1'b0; e_dv = 1'b0; e_err = 1'b0; e_data = '0;
    if (rst) begin
      pend_v = 1'b0; last_d = 1'b0;
      for (int i = 0; i < 32; i++) ref_mem[i] = seed_word(i);
    end else if (pend_v) begin
      e_iv = pend_i; e_dv = !pend_i; e_err = pend_err; e_data = pend_data; pend_v = 1'b0;
    end else if (iv && dv) begin
      gd = RR_EN ? !last_d : 1'b1;
      gi = !gd;
    end else begin
      gi = iv; gd = dv;
    end

    expect_eq("ibus_cmd_ready", 64'(ibus_cmd_ready), 64'(gi));
    expect_eq("dbus_cmd_ready", 64'(dbus_cmd_ready), 64'(gd));
    if (gi || gd) begin
      a     = gi ? ia : da;
      off   = a - BASE;
      inr   = off < WIN;
      w     = off >> 3;
      store = gd && dw;
      expect_eq("ram_en", 64'(ram_en), 64'(inr));
      if (inr) expect_eq("ram_idx", 64'(ram_idx), w);
      expect_eq("ram_wen", 64'(ram_wen), 64'(store && inr));
      if (store && inr) begin
        mask = '0;
        for (int b = 0; b < 8; b++) if (dst[b]) mask = mask | (64'hFF << (8 * b));
        expect_eq("ram_wdata", ram_wdata, dwd);
        expect_eq("ram_wmask", ram_wmask, mask);
        ref_mem[w[4:0]] = (ref_mem[w[4:0]] & ~mask) | (dwd & mask);
      end
      if (!store) begin
        val       = ref_mem[w[4:0]];
        pend_v    = 1'b1;
        pend_i    = gi;
        pend_err  = !inr;
        pend_data = !inr ? 64'd0 : (gi ? (a[2] ? {32'd0, val[63:32]} : {32'd0, val[31:0]}) : val);
      end
      last_d = gd;
    end else begin
      expect_eq("ram_en_idle", 64'(ram_en), 64'd0);
      expect_eq("ram_wen_idle", 64'(ram_wen), 64'd0);
    end
    expect_eq("ibus_rsp_valid", 64'(ibus_rsp_valid), 64'(e_iv));
    expect_eq("dbus_rsp_valid", 64'(dbus_rsp_valid), 64'(e_dv));
    if (e_iv) begin
      expect_eq("ibus_rsp_data", 64'(ibus_rsp_data), e_data);
      expect_eq("ibus_rsp_err", 64'(ibus_rsp_err), 64'(e_err));
    end
    if (e_dv) begin
      expect_eq("dbus_rsp_data", dbus_rsp_data, e_data);
      expect_eq("dbus_rsp_err", 64'(dbus_rsp_err), 64'(e_err));
    end
    acc_i = gi; acc_d = gd;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [63:0] rand_addr(input bit fetch);
    int unsigned r;
    logic [63:0] sub;
    r   = $urandom_range(0, 99);
    sub = fetch ? 64'(4 * $urandom_range(0, 1)) : 64'd0;
    if (r < 75)      return BASE + 64'(8 * $urandom_range(0, 31)) + sub;
    else if (r < 83) return BASE + WIN - 64'd8 + sub;
    else if (r < 91) return BASE + WIN + 64'(8 * $urandom_range(0, 3)) + sub;
    else if (r < 97) return BASE - 64'(8 * $urandom_range(1, 4)) + sub;
    else             return sub;
  endfunction

  initial begin
    bit          ai, ad, civ, cdv, cdw, rst_c;
    logic [63:0] cia, cda, cdwd;
    logic [7:0]  cdst;
    int          got_seq [6];
    int          n_g;

    @(posedge clock);
    #1;
    step(1, 0, 0, 0, 0, 0, 0, 0, ai, ad);
    step(1, 0, 0, 0, 0, 0, 0, 0, ai, ad);
    expect_eq("reset_ibus_ready", 64'(snap_ri), 64'd0);
    expect_eq("reset_ram_en", 64'(snap_en), 64'd0);

    // Fetch upper half of word 0 after storing a known pattern there.
    step(0, 0, 0, 1, BASE, 1, 64'h1111_2222_3333_4444, 8'hFF, ai, ad);
    step(0, 1, BASE + 64'd4, 0, 0, 0, 0, 0, ai, ad);
    expect_eq("t1_grant_idx", 64'(snap_idx), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, ai, ad);
    expect_eq("t1_rsp_data", 64'(snap_idata), 64'h1111_2222);
    expect_eq("t1_rsp_err", 64'(snap_ierr), 64'd0);

    // Partial store: low four byte lanes.
    step(0, 0, 0, 1, BASE + 64'h10, 1, 64'hAB, 8'h0F, ai, ad);
    expect_eq("t2_wen", 64'(snap_wen), 64'd1);
    expect_eq("t2_idx", 64'(snap_idx), 64'd2);
    expect_eq("t2_wmask", snap_wmask, 64'h0000_0000_FFFF_FFFF);
    step(0, 0, 0, 0, 0, 0, 0, 0, ai, ad);
    expect_eq("t2_no_rsp", 64'(snap_dv), 64'd0);

    // Load below the window.
    step(0, 0, 0, 1, 64'h7FFF_FFF8, 0, 0, 0, ai, ad);
    expect_eq("t4_ram_en", 64'(snap_en), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, ai, ad);
    expect_eq("t4_rsp_valid", 64'(snap_dv), 64'd1);
    expect_eq("t4_rsp_err", 64'(snap_derr), 64'd1);
    expect_eq("t4_rsp_data", snap_ddata, 64'd0);

    // Reset while a load response is pending.
    step(0, 0, 0, 1, BASE + 64'd8, 0, 0, 0, ai, ad);
    step(1, 0, 0, 0, 0, 0, 0, 0, ai, ad);
    expect_eq("t5_rsp_killed", 64'(snap_dv), 64'd0);
    step(0, 1, BASE, 0, 0, 0, 0, 0, ai, ad);
    expect_eq("t5_ibus_ready", 64'(snap_ri), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, ai, ad);
    step(0, 0, 0, 1, BASE, 0, 0, 0, ai, ad);
    expect_eq("t5_dbus_ready", 64'(snap_rd), 64'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, ai, ad);

    // Three back-to-back stores.
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, BASE + 64'(8 * k), 1, 64'(k) * 64'h0101_0101_0101_0101, 8'hFF, ai, ad);
      expect_eq("t6_ready", 64'(snap_rd), 64'd1);
      expect_eq("t6_idx", 64'(snap_idx), 64'(k));
    end

    // Both requesters continuously valid: record the first six grants.
    step(1, 0, 0, 0, 0, 0, 0, 0, ai, ad);
    for (int k = 0; k < 6; k++) got_seq[k] = 0;
    n_g = 0;
    for (int c = 0; c < 12; c++) begin
      step(0, 1, BASE + 64'd4, 1, BASE + 64'd8, 0, 0, 0, ai, ad);
      if (n_g < 6 && (snap_ri || snap_rd)) begin
        got_seq[n_g] = snap_rd ? 2 : 1;
        n_g++;
      end
    end
    for (int k = 0; k < 6; k++)
      expect_eq("t3_arb_seq", 64'(got_seq[k]), (RR_EN && (k % 2 == 1)) ? 64'd1 : 64'd2);

    // Randomized traffic with stable-while-waiting requesters.
    civ = 1'b0; cdv = 1'b0; ai = 1'b0; ad = 1'b0;
    cia = '0; cda = '0; cdw = 1'b0; cdwd = '0; cdst = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!civ || ai) begin
        civ = ($urandom_range(0, 99) < 55);
        cia = rand_addr(1'b1);
      end
      if (!cdv || ad) begin
        cdv  = ($urandom_range(0, 99) < 55);
        cda  = rand_addr(1'b0);
        cdw  = 1'($urandom_range(0, 1));
        cdwd = {$urandom, $urandom};
        cdst = 8'($urandom);
      end
      rst_c = ($urandom_range(0, 199) == 0);
      step(rst_c, civ, cia, cdv, cda, cdw, cdwd, cdst, ai, ad);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
